// File: rtl/audio_nios_sw_pkg.sv
// Shared constants and types for the slide-switch debounce block.
package audio_nios_sw_pkg;

    localparam int unsigned SW_WIDTH         = 18;
    localparam int unsigned TICK_DIV_DEF     = 50000;
    localparam int unsigned STABLE_TICKS_DEF = 10;
    localparam int unsigned CNT_W            = 4;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/audio_nios_sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer, tick-qualified stability counter, output flop.
module audio_nios_sw_debounce_bit
    import audio_nios_sw_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_out,
    output logic o_changed
);

    localparam cnt_t LAST = cnt_t'(STABLE_TICKS - 1);

    logic r_sync1;
    logic r_sync2;
    cnt_t r_cnt;
    logic r_out;
    logic r_changed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_out     <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_sync1   <= i_raw;
            r_sync2   <= r_sync1;
            r_changed <= 1'b0;
            // Any cycle of agreement discards progress: mismatch must be continuous.
            if (r_sync2 == r_out) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == LAST) begin
                    r_out     <= ~r_out;
                    r_cnt     <= '0;
                    r_changed <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + cnt_t'(1);
                end
            end
        end
    end

    assign o_out     = r_out;
    assign o_changed = r_changed;

endmodule

// File: rtl/audio_nios_sw_debounce.sv
// Debounces the board slide switches before the switch PIO; shared prescaler plus per-bit filters.
module audio_nios_sw_debounce
    import audio_nios_sw_pkg::*;
#(
    parameter int unsigned WIDTH        = SW_WIDTH,
    parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_changed,
    output logic             tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic          r_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= (r_presc == PRESC_LAST);
            if (r_presc == PRESC_LAST) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign tick = r_tick;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        audio_nios_sw_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .i_raw    (sw_raw[g]),
            .i_tick   (r_tick),
            .o_out    (sw_out[g]),
            .o_changed(sw_changed[g])
        );
    end

endmodule

// File: tb/tb_audio_nios_sw_debounce.sv
// Directed bench for audio_nios_sw_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_audio_nios_sw_debounce;

    logic        clk;
    logic        reset;
    logic [17:0] sw_raw;
    logic [17:0] sw_out;
    logic [17:0] sw_changed;
    logic        tick;

    int n_checks = 0;
    int n_fail   = 0;

    audio_nios_sw_debounce #(
        .WIDTH       (18),
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .sw_out    (sw_out),
        .sw_changed(sw_changed),
        .tick      (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Waits up to maxc cycles for (sw_out & mask) == want; n = cycles taken (maxc+1 on timeout),
    // pre = OR of sw_changed seen before the hit cycle.
    task automatic wait_out(input logic [17:0] mask, input logic [17:0] want, input int maxc,
                            output int n, output logic [17:0] pre);
        pre = '0;
        n   = maxc + 1;
        for (int i = 1; i <= maxc; i++) begin
            @(posedge clk);
            #1;
            if ((sw_out & mask) == want) begin
                n = i;
                return;
            end
            pre = pre | sw_changed;
        end
    endtask

    initial begin
        int          n;
        logic [17:0] pre;
        int          bad;
        int          bad2;
        int          pulses;
        int          last;
        logic [17:0] ref_out;

        reset  = 1'b0;
        sw_raw = '0;

        // Asynchronous reset: checked before the first clock edge at t=5.
        #2 reset = 1'b1;
        sw_raw = 18'h3FFFF;
        #1;
        check("reset_sw_out", 32'(sw_out), 32'h0);
        check("reset_sw_changed", 32'(sw_changed), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        sw_raw = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_sw_out", 32'(sw_out), 32'h0);

        // Clean step on bit 0.
        sw_raw[0] = 1'b1;
        wait_out(18'h00001, 18'h00001, 20, n, pre);
        check("step_latency_in_11_15", 32'((n >= 11) && (n <= 15)), 32'h1);
        check("step_sw_out", 32'(sw_out), 32'h00001);
        check("step_sw_changed", 32'(sw_changed), 32'h00001);
        check("step_no_early_pulse", 32'(pre), 32'h0);
        @(posedge clk);
        #1;
        check("step_pulse_one_cycle", 32'(sw_changed), 32'h0);

        // Bounce on bit 5: 3-cycle mismatch windows never span enough ticks.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            sw_raw[5] = ~sw_raw[5];
            repeat (3) begin
                @(posedge clk);
                #1;
                if (sw_out[5] || sw_changed[5]) bad++;
            end
        end
        repeat (20) begin
            @(posedge clk);
            #1;
            if (sw_out[5] || sw_changed[5]) bad++;
        end
        check("bounce_no_toggle", 32'(bad), 32'h0);
        sw_raw[5] = 1'b1;
        wait_out(18'h00020, 18'h00020, 20, n, pre);
        check("bounce_settle_latency", 32'((n >= 11) && (n <= 15)), 32'h1);
        check("bounce_settle_sw_out", 32'(sw_out), 32'h00021);

        // Return to all-zero, then simultaneous all-bit steps.
        sw_raw = '0;
        wait_out(18'h3FFFF, 18'h00000, 20, n, pre);
        check("clear_sw_out", 32'(sw_out), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        sw_raw = 18'h3FFFF;
        wait_out(18'h3FFFF, 18'h3FFFF, 20, n, pre);
        check("all_rise_sw_out", 32'(sw_out), 32'h3FFFF);
        check("all_rise_sw_changed", 32'(sw_changed), 32'h3FFFF);
        check("all_rise_no_early_pulse", 32'(pre), 32'h0);
        @(posedge clk);
        #1;
        check("all_rise_pulse_end", 32'(sw_changed), 32'h0);
        sw_raw = '0;
        wait_out(18'h3FFFF, 18'h00000, 20, n, pre);
        check("all_fall_sw_out", 32'(sw_out), 32'h0);
        check("all_fall_sw_changed", 32'(sw_changed), 32'h3FFFF);
        check("all_fall_no_early_pulse", 32'(pre), 32'h0);
        @(posedge clk);
        #1;
        check("all_fall_pulse_end", 32'(sw_changed), 32'h0);

        // Reset one tick period after a step on bit 3; full requalification afterwards.
        repeat (3) @(posedge clk);
        #1;
        sw_raw[3] = 1'b1;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("midreset_sw_out", 32'(sw_out), 32'h0);
        check("midreset_sw_changed", 32'(sw_changed), 32'h0);
        check("midreset_tick", 32'(tick), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_out(18'h00008, 18'h00008, 20, n, pre);
        check("midreset_requal_latency", 32'((n >= 11) && (n <= 15)), 32'h1);
        check("midreset_requal_sw_out", 32'(sw_out), 32'h00008);
        check("midreset_requal_changed", 32'(sw_changed), 32'h00008);

        // Tick cadence with static inputs.
        repeat (2) @(posedge clk);
        #1;
        ref_out = sw_out;
        bad     = 0;
        bad2    = 0;
        pulses  = 0;
        last    = -1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                pulses++;
                if ((last >= 0) && (i - last != 4)) bad++;
                last = i;
            end
            if ((sw_out != ref_out) || (sw_changed != 18'h0)) bad2++;
        end
        check("tick_pulse_count", 32'(pulses), 32'd5);
        check("tick_spacing", 32'(bad), 32'h0);
        check("static_outputs", 32'(bad2), 32'h0);
        check("static_sw_out", 32'(sw_out), 32'h00008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
